// File: rtl/cplx_acc_collector.sv
// cplx_acc_collector
//   Downstream stage of the 4-DSP complex ALU. The unregistered {I,Q} ALU
//   result is re-timed against the issue strobe. A programmable number of
//   complex products is accumulated, and each finished sum is reduced to
//   DATA_WIDTH per component and queued in a small result FIFO with a
//   valid/ready output.
//
//   Build option: CPLX_ACC_SAT_EN
//     defined   - each component saturates to the signed DATA_WIDTH range;
//                 any clip sets the sticky sat_flag
//     undefined - each component wraps (low DATA_WIDTH bits); sat_flag = 0
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   issue_valid operands issued to the ALU this cycle
//   clear       synchronous flush of partial sum and in-flight samples
//   acc_len     products per result (0 is treated as 1)
//   alu_dout    {I,Q} ALU result, signed, valid ALU_LATENCY cycles after issue
//   stall       upstream must not issue
//   dout        {I,Q} result at the FIFO head
//   dout_valid  FIFO non-empty
//   dout_ready  consumer accepts dout
//   ovf_err     sticky: a result was dropped on a full FIFO
//   sat_flag    sticky: a result was clipped
//
// state  | meaning
// S_IDLE | no partial sum; next sample starts a group
// S_ACC  | group in progress, cnt samples accumulated so far
module cplx_acc_collector #(
  parameter int DATA_WIDTH  = 16,
  parameter int ALU_LATENCY = 4,
  parameter int ACC_WIDTH   = 24,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic                    clear,
  input  logic [7:0]              acc_len,
  input  logic [2*DATA_WIDTH-1:0] alu_dout,
  output logic                    stall,
  output logic [2*DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    ovf_err,
  output logic                    sat_flag
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = ACC_WIDTH - DATA_WIDTH;

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t                        state, state_nxt;
  logic [ALU_LATENCY-1:0]        vld_sr;
  logic                          smp_v;
  logic signed [ACC_WIDTH-1:0]   ext_i, ext_q, fin_i, fin_q;
  logic signed [ACC_WIDTH-1:0]   acc_i, acc_q, acc_i_nxt, acc_q_nxt;
  logic [7:0]                    cnt, cnt_nxt, len_q, len_nxt;
  logic                          complete;
  logic [DATA_WIDTH-1:0]         res_i, res_q;

  logic [2*DATA_WIDTH-1:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [CW-1:0]                 count;
  logic                          full, pop, push, drop;

  assign smp_v = vld_sr[ALU_LATENCY-1];
  assign ext_i = {{XW{alu_dout[2*DATA_WIDTH-1]}}, alu_dout[2*DATA_WIDTH-1:DATA_WIDTH]};
  assign ext_q = {{XW{alu_dout[DATA_WIDTH-1]}}, alu_dout[DATA_WIDTH-1:0]};
  // Running sum including the current sample; a new group starts from the sample alone.
  assign fin_i = (state == S_ACC) ? acc_i + ext_i : ext_i;
  assign fin_q = (state == S_ACC) ? acc_q + ext_q : ext_q;

  always_comb begin
    state_nxt = state;
    acc_i_nxt = acc_i;
    acc_q_nxt = acc_q;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    complete  = 1'b0;
    case (state)
      S_IDLE: begin
        if (smp_v) begin
          len_nxt   = (acc_len == 8'd0) ? 8'd1 : acc_len;
          acc_i_nxt = fin_i;
          acc_q_nxt = fin_q;
          cnt_nxt   = 8'd1;
          if (acc_len <= 8'd1) complete  = 1'b1;
          else                 state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        if (smp_v) begin
          acc_i_nxt = fin_i;
          acc_q_nxt = fin_q;
          cnt_nxt   = cnt + 8'd1;
          if ((cnt + 8'd1) == len_q) begin
            complete  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (clear) begin
      state_nxt = S_IDLE;
      acc_i_nxt = '0;
      acc_q_nxt = '0;
      cnt_nxt   = '0;
      complete  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      vld_sr <= '0;
      acc_i  <= '0;
      acc_q  <= '0;
      cnt    <= '0;
      len_q  <= '0;
    end else begin
      state  <= state_nxt;
      vld_sr <= clear ? '0 : ((vld_sr << 1) | ALU_LATENCY'(issue_valid));
      acc_i  <= acc_i_nxt;
      acc_q  <= acc_q_nxt;
      cnt    <= cnt_nxt;
      len_q  <= len_nxt;
    end
  end

`ifdef CPLX_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(XW+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(XW+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic clip;

  function automatic logic [DATA_WIDTH-1:0] sat_fn(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_MAX)      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                  return v[DATA_WIDTH-1:0];
  endfunction

  assign res_i = sat_fn(fin_i);
  assign res_q = sat_fn(fin_q);
  assign clip  = (fin_i > SAT_MAX) || (fin_i < SAT_MIN) || (fin_q > SAT_MAX) || (fin_q < SAT_MIN);

  // Clipping counts even when the result is then dropped on a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 sat_flag <= 1'b0;
    else if (complete && clip) sat_flag <= 1'b1;
  end
`else
  assign res_i    = fin_i[DATA_WIDTH-1:0];
  assign res_q    = fin_q[DATA_WIDTH-1:0];
  assign sat_flag = 1'b0;
`endif

  assign full       = (count == CW'(FIFO_DEPTH));
  assign dout_valid = (count != '0);
  assign dout       = mem[rd_ptr];
  assign stall      = (count >= CW'(FIFO_DEPTH - 1));
  assign pop        = dout_valid && dout_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push       = complete && (!full || pop);
  assign drop       = complete && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {res_i, res_q};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) ovf_err <= 1'b1;
    end
  end

endmodule

// File: doc/cplx_acc_collector.md
Name: cplx_acc_collector

Overview:
- Downstream stage of the 4-DSP complex ALU.
- Re-times the ALU's unregistered {I,Q} result against the issue strobe and accumulates a programmable number of complex products (dot-product / correlation).
- Saturates or wraps each sum to 16-bit I/Q and buffers finished results in a small FIFO with a valid/ready output.

Parameters:
- DATA_WIDTH, 16, width of each I and Q component
- ALU_LATENCY, 4, cycles from issue_valid to the matching alu_dout
- ACC_WIDTH, 24, signed accumulator width per component
- FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  operands issued to ALU this cycle
- clear  in  1  synchronous flush of partial accumulation and in-flight samples
- acc_len  in  8  products per result; 0 treated as 1
- alu_dout  in  2*DATA_WIDTH  {I[31:16], Q[15:0]}, signed two's complement
- stall  out  1  upstream must not assert issue_valid
- dout  out  2*DATA_WIDTH  {I,Q} result at FIFO head
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts dout
- ovf_err  out  1  sticky: result dropped on full FIFO
- sat_flag  out  1  sticky: a result was clipped (SAT_EN only, else 0)

Behaviour:
- Reset (rst low, asynchronous): delay line valids, accumulators, count, FIFO pointers/count, state, ovf_err and sat_flag all 0; dout=0, dout_valid=0, stall=0.
- Delay line: ALU_LATENCY-deep shift of issue_valid. Tap output smp_v qualifies alu_dout in that cycle. At most one sample per cycle.
- FSM:
  - IDLE: no partial sum. On smp_v: latch len_q = max(acc_len,1); acc_i/acc_q = sign-extended sample; cnt=1. If len_q==1, complete this edge and stay IDLE; else go to ACC.
  - ACC: on smp_v: acc += sign-extended sample (ACC_WIDTH, wraps on internal overflow); cnt++. When cnt+1==len_q, complete and go to IDLE.
  - Completion pushes the result, formed from the sum including the current sample, into the FIFO on the same edge.
  - acc_len changes mid-group are ignored until the next group.
- Result formation: component = acc reduced to DATA_WIDTH per the Optional Feature.
- FIFO:
  - dout = mem[rd_ptr]; dout_valid = count!=0.
  - Pop when dout_valid && dout_ready.
  - Push when a group completes. If full and no pop that cycle, drop the result and set ovf_err (held until reset).
  - Full with simultaneous push and pop: both succeed, no error.
  - Empty with dout_ready high: no pop.
  - Pointers wrap modulo FIFO_DEPTH.
- stall = (count >= FIFO_DEPTH-1), combinational from registered count. Upstream honouring stall guarantees no drop for acc_len >= ALU_LATENCY. Shorter groups are the issuer's responsibility.
- clear (high for one or more cycles):
  - Zeroes the delay line, accumulators and cnt; FSM to IDLE.
  - FIFO, ovf_err and sat_flag are untouched.
  - A completion coinciding with clear is discarded.
- Latency: issue at cycle t, acc_len=1, empty FIFO: dout_valid high at t+ALU_LATENCY+1.

Optional Feature:
- Macro: CPLX_ACC_SAT_EN
- Defined:
  - Each component saturates to the signed DATA_WIDTH range: values > 32767 become 32767 (0x7FFF); values < -32768 become -32768 (0x8000).
  - Any clip sets sat_flag (sticky until reset).
- Undefined:
  - Component = acc[DATA_WIDTH-1:0] (wrap).
  - sat_flag tied 0; no saturation logic generated.

Test Plan:
- Reset/latency: rst low then high; acc_len=1; issue at cycle 10 with alu_dout={16'h0003,16'hFFFE} at cycle 14 -> dout_valid rises cycle 15, dout=32'h0003FFFE; all outputs 0 during reset.
- Accumulate 4: acc_len=4; samples I=1000,2000,-500,10 and Q=-1,-1,-1,-1 on consecutive tap cycles -> single result I=2510 (0x09CE), Q=-4 (0xFFFC); no output before the 4th sample.
- Saturation: acc_len=2; two samples I=30000, Q=-30000 -> with CPLX_ACC_SAT_EN: dout=32'h7FFF8000, sat_flag=1. Without: I=0xEA60, Q=0x15A0, sat_flag=0.
- FIFO full/stall: dout_ready=0, acc_len=1, continuous issue ignoring stall -> stall high once count=3; 5th result dropped, ovf_err=1, FIFO holds the first 4 in order. Then dout_ready=1 with a push the same cycle while full -> no additional error.
- Clear mid-group: acc_len=8, 3 samples in, clear pulsed with 2 issues in flight -> those samples ignored. Next group of 8 samples value {1,1} -> dout=32'h00080008.
- acc_len=0 and async reset mid-ACC: acc_len=0 -> every sample yields one result. Assert rst during ACC -> outputs 0 immediately without a clock edge; FIFO empty.
